// File: rtl/char_text_buffer.sv
`default_nettype none
// ============================================================================
// Module      : char_text_buffer
// Description : Character-cell text RAM for the text-overlay stage. Returns
//               the code of cell char_xy one clock later (read-first), accepts
//               cell writes over a valid/ready port and blanks itself with
//               FILL_CHAR after reset or on clr_req.
//               Optional score renderer enabled by macro CHAR_BUF_SCORE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module char_text_buffer #(
    parameter int unsigned DEPTH        = 256,
    parameter logic [7:0]  FILL_CHAR    = 8'h20,
    parameter int unsigned SCORE_ADDR   = 0,
    parameter int unsigned SCORE_DIGITS = 5
) (
    input  logic        clk,
    input  logic        rst,          // asynchronous, active-low
    input  logic [7:0]  char_xy,
    output logic [7:0]  char_code,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [7:0]  wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        clr_req,
    output logic        busy,
    input  logic [13:0] score_in,
    input  logic        score_load
);

    typedef enum logic [1:0] {
        S_CLEAR      = 2'd0,
        S_IDLE       = 2'd1,
        S_SCORE_CONV = 2'd2,
        S_SCORE_WR   = 2'd3
    } state_t;

    localparam logic [8:0] c_depth = 9'(DEPTH);
    localparam logic [7:0] c_last  = 8'(DEPTH - 1);

    state_t     r_state;
    logic [7:0] r_clr_ptr;
    logic [7:0] r_char_code;
    logic [7:0] r_mem [DEPTH];

    logic       w_xy_oob;
    logic       w_wa_oob;
    logic       w_we;
    logic [7:0] w_waddr;
    logic [7:0] w_wdata;

    assign w_xy_oob  = ({1'b0, char_xy} >= c_depth);
    assign w_wa_oob  = ({1'b0, wr_addr} >= c_depth);
    assign busy      = (r_state != S_IDLE);
    assign char_code = r_char_code;

`ifdef CHAR_BUF_SCORE_EN
    localparam int unsigned c_bcd_w    = 4 * SCORE_DIGITS;
    localparam logic [7:0]  c_last_dig = 8'(SCORE_DIGITS - 1);

    logic [13:0]        r_bin;
    logic [c_bcd_w-1:0] r_bcd;
    logic [3:0]         r_cnt;
    logic [7:0]         r_dig;
    logic [c_bcd_w-1:0] w_bcd_adj;
    logic [31:0]        w_score_idx;
    logic [3:0]         w_msd;

    // Double-dabble add-3 correction on every BCD digit before each shift;
    // carries out of the top digit are dropped, giving the value mod 10^N.
    generate
        for (genvar g = 0; g < int'(SCORE_DIGITS); g++) begin : g_dabble
            assign w_bcd_adj[4*g +: 4] = (r_bcd[4*g +: 4] >= 4'd5) ?
                                         (r_bcd[4*g +: 4] + 4'd3) : r_bcd[4*g +: 4];
        end
    endgenerate

    assign w_score_idx = SCORE_ADDR + {24'd0, r_dig};
    assign w_msd       = r_bcd[c_bcd_w-1 -: 4];
    assign wr_ready    = (r_state == S_IDLE) & ~clr_req & ~score_load;
`else
    logic w_unused_score;
    assign w_unused_score = ^{score_in, score_load, SCORE_ADDR, SCORE_DIGITS};
    assign wr_ready       = (r_state == S_IDLE) & ~clr_req;
`endif

    // Select the single RAM write source for this cycle from the current state
    always_comb begin
        w_we    = 1'b0;
        w_waddr = wr_addr;
        w_wdata = wr_data;
        case (r_state)
            S_CLEAR: begin
                w_we    = 1'b1;
                w_waddr = r_clr_ptr;
                w_wdata = FILL_CHAR;
            end
            S_IDLE: begin
                w_we = wr_valid & wr_ready & ~w_wa_oob;
            end
`ifdef CHAR_BUF_SCORE_EN
            S_SCORE_WR: begin
                w_we    = ~clr_req & (w_score_idx < DEPTH);
                w_waddr = w_score_idx[7:0];
                w_wdata = {4'h3, w_msd};
            end
`endif
            default: ;
        endcase
    end

    // Cell storage; intentionally not reset, the clear pass initialises it
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Sequencer FSM plus the registered read port (read-first, never stalled)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_CLEAR;
            r_clr_ptr   <= '0;
            r_char_code <= '0;
`ifdef CHAR_BUF_SCORE_EN
            r_bin       <= '0;
            r_bcd       <= '0;
            r_cnt       <= '0;
            r_dig       <= '0;
`endif
        end else begin
            r_char_code <= ((r_state == S_CLEAR) || w_xy_oob) ? FILL_CHAR : r_mem[char_xy];
            case (r_state)
                S_CLEAR: begin
                    if (clr_req) begin
                        r_clr_ptr <= '0;
                    end else if (r_clr_ptr == c_last) begin
                        r_clr_ptr <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_clr_ptr <= r_clr_ptr + 8'd1;
                    end
                end
                S_IDLE: begin
                    if (clr_req) begin
                        r_state   <= S_CLEAR;
                        r_clr_ptr <= '0;
                    end
`ifdef CHAR_BUF_SCORE_EN
                    else if (score_load) begin
                        r_state <= S_SCORE_CONV;
                        r_bin   <= score_in;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                    end
`endif
                end
`ifdef CHAR_BUF_SCORE_EN
                S_SCORE_CONV: begin
                    if (clr_req) begin
                        r_state   <= S_CLEAR;
                        r_clr_ptr <= '0;
                    end else begin
                        r_bcd <= {w_bcd_adj[c_bcd_w-2:0], r_bin[13]};
                        r_bin <= {r_bin[12:0], 1'b0};
                        r_cnt <= r_cnt + 4'd1;
                        if (r_cnt == 4'd13) begin
                            r_state <= S_SCORE_WR;
                            r_dig   <= '0;
                        end
                    end
                end
                S_SCORE_WR: begin
                    if (clr_req) begin
                        r_state   <= S_CLEAR;
                        r_clr_ptr <= '0;
                    end else begin
                        r_bcd <= r_bcd << 4;
                        r_dig <= r_dig + 8'd1;
                        if (r_dig == c_last_dig) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
`endif
                default: begin
                    r_state   <= S_CLEAR;
                    r_clr_ptr <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_char_text_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_char_text_buffer
// Description : Directed self-checking bench for char_text_buffer. Drives a
//               DEPTH=256 instance (a) and a DEPTH=200 instance (b) from the
//               same stimulus. Score checks compile in with CHAR_BUF_SCORE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_char_text_buffer;

    logic        clk = 1'b0;
    logic        r_rst;
    logic [7:0]  r_char_xy;
    logic        r_wr_valid;
    logic [7:0]  r_wr_addr;
    logic [7:0]  r_wr_data;
    logic        r_clr_req;
    logic [13:0] r_score_in;
    logic        r_score_load;

    logic [7:0]  w_code_a, w_code_b;
    logic        w_ready_a, w_ready_b;
    logic        w_busy_a, w_busy_b;

    int total = 0;
    int bad   = 0;
    int n;
    int nbad;

    always #5 clk = ~clk;

    char_text_buffer #(.DEPTH(256)) u_dut_a (
        .clk(clk), .rst(r_rst), .char_xy(r_char_xy), .char_code(w_code_a),
        .wr_valid(r_wr_valid), .wr_ready(w_ready_a), .wr_addr(r_wr_addr),
        .wr_data(r_wr_data), .clr_req(r_clr_req), .busy(w_busy_a),
        .score_in(r_score_in), .score_load(r_score_load)
    );

    char_text_buffer #(.DEPTH(200)) u_dut_b (
        .clk(clk), .rst(r_rst), .char_xy(r_char_xy), .char_code(w_code_b),
        .wr_valid(r_wr_valid), .wr_ready(w_ready_b), .wr_addr(r_wr_addr),
        .wr_data(r_wr_data), .clr_req(r_clr_req), .busy(w_busy_b),
        .score_in(r_score_in), .score_load(r_score_load)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [7:0] addr);
        r_char_xy = addr;
        tick();
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (w_busy_a === 1'b1 && cycles < 2000) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        r_rst        = 1'b0;
        r_char_xy    = 8'd0;
        r_wr_valid   = 1'b0;
        r_wr_addr    = 8'd0;
        r_wr_data    = 8'd0;
        r_clr_req    = 1'b0;
        r_score_in   = 14'd0;
        r_score_load = 1'b0;

        // ---- reset and power-up clear ----
        repeat (3) tick();
        check("reset_code", {24'd0, w_code_a}, 32'h0);
        check("reset_busy", {31'd0, w_busy_a}, 32'd1);
        check("reset_ready", {31'd0, w_ready_a}, 32'd0);
        r_rst = 1'b1;
        n = 0;
        nbad = 0;
        while (w_busy_a === 1'b1 && n < 2000) begin
            tick();
            n++;
            if (w_code_a !== 8'h20) nbad++;
        end
        check("clear_cycles", n, 256);
        check("clear_fill_reads", nbad, 0);
        check("idle_busy_b", {31'd0, w_busy_b}, 32'd0);
        nbad = 0;
        for (int i = 0; i < 256; i++) begin
            rd(8'(i));
            if (w_code_a !== 8'h20) nbad++;
            if (w_code_b !== 8'h20) nbad++;
        end
        check("scan_after_clear", nbad, 0);

        // ---- basic write, read-first ----
        r_wr_valid = 1'b1;
        r_wr_addr  = 8'd5;
        r_wr_data  = 8'h41;
        r_char_xy  = 8'd5;
        #1;
        check("wr_ready_idle", {31'd0, w_ready_a}, 32'd1);
        tick();
        r_wr_valid = 1'b0;
        check("read_first", {24'd0, w_code_a}, 32'h20);
        tick();
        check("read_after_write", {24'd0, w_code_a}, 32'h41);
        rd(8'd6);
        check("neighbour_cell", {24'd0, w_code_a}, 32'h20);

        // ---- clr_req beats write, clear restart ----
        r_wr_valid = 1'b1;
        r_wr_addr  = 8'd7;
        r_wr_data  = 8'h55;
        r_clr_req  = 1'b1;
        #1;
        check("wr_ready_clr", {31'd0, w_ready_a}, 32'd0);
        tick();
        r_wr_valid = 1'b0;
        r_clr_req  = 1'b0;
        check("busy_clear", {31'd0, w_busy_a}, 32'd1);
        repeat (100) tick();
        r_clr_req = 1'b1;
        tick();
        r_clr_req = 1'b0;
        wait_idle(n);
        check("restart_total", 101 + n, 357);
        rd(8'd5);
        check("cleared_cell5", {24'd0, w_code_a}, 32'h20);
        rd(8'd7);
        check("dropped_write7", {24'd0, w_code_a}, 32'h20);

        // ---- out-of-range write on DEPTH=200 ----
        r_wr_valid = 1'b1;
        r_wr_addr  = 8'hFF;
        r_wr_data  = 8'h77;
        #1;
        check("oob_ready_b", {31'd0, w_ready_b}, 32'd1);
        tick();
        r_wr_valid = 1'b0;
        nbad = 0;
        for (int i = 0; i < 200; i++) begin
            rd(8'(i));
            if (w_code_b !== 8'h20) nbad++;
        end
        check("oob_no_change_b", nbad, 0);
        rd(8'd250);
        check("oob_read_b", {24'd0, w_code_b}, 32'h20);
        rd(8'hFF);
        check("inrange_ff_a", {24'd0, w_code_a}, 32'h77);
        r_wr_valid = 1'b1;
        r_wr_addr  = 8'd199;
        r_wr_data  = 8'h5A;
        tick();
        r_wr_valid = 1'b0;
        rd(8'd199);
        check("last_cell_b", {24'd0, w_code_b}, 32'h5A);
        rd(8'd200);
        check("first_oob_b", {24'd0, w_code_b}, 32'h20);

        // ---- async reset during a clear pass ----
        r_clr_req = 1'b1;
        tick();
        r_clr_req = 1'b0;
        repeat (50) tick();
        r_rst = 1'b0;
        #1;
        check("async_rst_code", {24'd0, w_code_a}, 32'h0);
        check("async_rst_busy", {31'd0, w_busy_a}, 32'd1);
        tick();
        r_rst = 1'b1;
        wait_idle(n);
        check("rst_reclear_cycles", n, 256);
        rd(8'hFF);
        check("reclear_ff_a", {24'd0, w_code_a}, 32'h20);
        rd(8'd199);
        check("reclear_199_b", {24'd0, w_code_b}, 32'h20);

`ifdef CHAR_BUF_SCORE_EN
        // ---- score rendering ----
        r_score_in   = 14'd1234;
        r_score_load = 1'b1;
        #1;
        check("ready_score_load", {31'd0, w_ready_a}, 32'd0);
        tick();
        r_score_load = 1'b0;
        wait_idle(n);
        check("score_busy", n, 19);
        nbad = 0;
        for (int i = 0; i < 5; i++) begin
            rd(8'(i));
            if (w_code_a !== 8'(8'h30 + ((i == 0) ? 0 : i))) nbad++;
        end
        check("score_1234", nbad, 0);
        r_score_in   = 14'd16383;
        r_score_load = 1'b1;
        tick();
        r_score_load = 1'b0;
        wait_idle(n);
        rd(8'd0);
        check("score16383_d0", {24'd0, w_code_a}, 32'h31);
        rd(8'd1);
        check("score16383_d1", {24'd0, w_code_a}, 32'h36);
        rd(8'd2);
        check("score16383_d2", {24'd0, w_code_a}, 32'h33);
        rd(8'd3);
        check("score16383_d3", {24'd0, w_code_a}, 32'h38);
        rd(8'd4);
        check("score16383_d4", {24'd0, w_code_a}, 32'h33);
        r_score_in   = 14'd999;
        r_score_load = 1'b1;
        tick();
        r_score_load = 1'b0;
        repeat (3) tick();
        r_rst = 1'b0;
        #1;
        check("score_rst_busy", {31'd0, w_busy_a}, 32'd1);
        tick();
        r_rst = 1'b1;
        wait_idle(n);
        check("score_rst_clear", n, 256);
        nbad = 0;
        for (int i = 0; i < 5; i++) begin
            rd(8'(i));
            if (w_code_a !== 8'h20) nbad++;
        end
        check("score_cells_blank", nbad, 0);
`else
        // ---- score_load has no effect without the renderer ----
        r_score_in   = 14'd1234;
        r_score_load = 1'b1;
        r_wr_valid   = 1'b1;
        r_wr_addr    = 8'd3;
        r_wr_data    = 8'h33;
        #1;
        check("ready_score_ignored", {31'd0, w_ready_a}, 32'd1);
        tick();
        r_score_load = 1'b0;
        r_wr_valid   = 1'b0;
        check("busy_score_ignored", {31'd0, w_busy_a}, 32'd0);
        rd(8'd3);
        check("write_with_score_load", {24'd0, w_code_a}, 32'h33);
        rd(8'd0);
        check("cell0_untouched", {24'd0, w_code_a}, 32'h20);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
